// File: rtl/sp_ram_param.sv
// Parametrised single-port synchronous RAM with byte-lane writes, selectable read
// latency and write-port behaviour, a clear-on-reset sequencer and address range flagging.
module sp_ram_param #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 3,
    parameter int DEPTH      = 1 << ADDR_W,
    parameter int OUT_REG    = 0,
    parameter int WRITE_MODE = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                wea,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   din,
    input  logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   dout,
    output logic                read_valid,
    output logic                ready,
    output logic                addr_err
);
    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0]   LAST_IDX  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [DATA_W-1:0] WORD_ZERO = {DATA_W{1'b0}};

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t RST_STATE = (INIT_CLEAR != 0) ? ST_INIT : ST_READY;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [NB-1:0]     lanes
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < NB; i++) begin
            if (lanes[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W:0]     init_cnt_r;
    logic [ADDR_W:0]     init_cnt_nxt_s;
    logic                ready_r;
    logic [DATA_W-1:0]   mem_r [0:DEPTH-1];

    logic                acc_s;
    logic                oor_s;
    logic [DATA_W-1:0]   rd_word_s;
    logic [DATA_W-1:0]   wr_word_s;
    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_idx_s;
    logic [DATA_W-1:0]   mem_wdata_s;
    logic                s1_valid_s;
    logic                s1_err_s;
    logic [DATA_W-1:0]   s1_data_s;
    logic                o_valid_s;
    logic                o_err_s;
    logic [DATA_W-1:0]   o_data_s;
    logic [DATA_W-1:0]   dout_r;
    logic                read_valid_r;
    logic                addr_err_r;

    // Next-state logic: INIT walks the clear counter up to the last word, then READY.
    always_comb begin
        state_nxt_s    = state_r;
        init_cnt_nxt_s = init_cnt_r;
        case (state_r)
            ST_INIT: begin
                if (init_cnt_r == LAST_IDX) begin
                    state_nxt_s    = ST_READY;
                    init_cnt_nxt_s = CNT_ZERO;
                end else begin
                    init_cnt_nxt_s = init_cnt_r + CNT_ONE;
                end
            end
            ST_READY: begin
                state_nxt_s = ST_READY;
            end
            default: begin
                state_nxt_s    = RST_STATE;
                init_cnt_nxt_s = CNT_ZERO;
            end
        endcase
    end

    // FSM state, clear counter and ready flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= RST_STATE;
            init_cnt_r <= CNT_ZERO;
            ready_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            init_cnt_r <= init_cnt_nxt_s;
            ready_r    <= (state_nxt_s == ST_READY);
        end
    end

    assign acc_s = ena & ready_r;
    assign oor_s = ({1'b0, addr} >= DEPTH_W);

    // Array read port and byte-merged write word; out-of-range reads return zero.
    always_comb begin
        rd_word_s = WORD_ZERO;
        if (oor_s) begin
            rd_word_s = WORD_ZERO;
        end else begin
            rd_word_s = mem_r[addr];
        end
        wr_word_s = merge_bytes(rd_word_s, din, be);
    end

    // Array write selection: the clear sequencer owns the port while in INIT.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_idx_s   = addr;
        mem_wdata_s = wr_word_s;
        if (state_r == ST_INIT) begin
            mem_we_s    = 1'b1;
            mem_idx_s   = init_cnt_r[ADDR_W-1:0];
            mem_wdata_s = WORD_ZERO;
        end else if (acc_s && wea && !oor_s) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Storage array; contents are deliberately left out of the reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_idx_s] <= mem_wdata_s;
        end
    end

    // First read stage: what an accepted access presents on dout.
    always_comb begin
        s1_valid_s = 1'b0;
        s1_err_s   = 1'b0;
        s1_data_s  = WORD_ZERO;
        if (acc_s) begin
            s1_err_s = oor_s;
            if (!wea) begin
                s1_valid_s = 1'b1;
                s1_data_s  = rd_word_s;
            end else if (WRITE_MODE != 0) begin
                s1_valid_s = 1'b1;
                s1_data_s  = oor_s ? WORD_ZERO : wr_word_s;
            end else begin
                s1_valid_s = 1'b0;
            end
        end else begin
            s1_err_s = 1'b0;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              p_valid_r;
            logic              p_err_r;
            logic [DATA_W-1:0] p_data_r;

            // Extra pipeline register for the two-cycle read option.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    p_valid_r <= 1'b0;
                    p_err_r   <= 1'b0;
                    p_data_r  <= WORD_ZERO;
                end else begin
                    p_valid_r <= s1_valid_s;
                    p_err_r   <= s1_err_s;
                    p_data_r  <= s1_data_s;
                end
            end

            assign o_valid_s = p_valid_r;
            assign o_err_s   = p_err_r;
            assign o_data_s  = p_data_r;
        end else begin : g_no_out_reg
            assign o_valid_s = s1_valid_s;
            assign o_err_s   = s1_err_s;
            assign o_data_s  = s1_data_s;
        end
    endgenerate

    // Output registers; dout only moves when a valid word arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_r       <= WORD_ZERO;
            read_valid_r <= 1'b0;
            addr_err_r   <= 1'b0;
        end else begin
            read_valid_r <= o_valid_s;
            addr_err_r   <= o_err_s;
            if (o_valid_s) begin
                dout_r <= o_data_s;
            end else begin
                dout_r <= dout_r;
            end
        end
    end

    assign dout       = dout_r;
    assign read_valid = read_valid_r;
    assign ready      = ready_r;
    assign addr_err   = addr_err_r;

endmodule

// File: tb/tb_sp_ram_param.sv
// Bench for sp_ram_param: five configurations driven in parallel and checked every
// cycle against a word-level behavioural model, plus hand-computed spot checks.
module tb_sp_ram_param;
    localparam int NI = 5;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        ena  = 1'b0;
    logic        wea  = 1'b0;
    logic [3:0]  be   = 4'h0;
    logic [31:0] din  = 32'h0;
    logic [2:0]  addr = 3'd0;

    logic [31:0] dout_a  [NI];
    logic        valid_a [NI];
    logic        ready_a [NI];
    logic        err_a   [NI];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sp_ram_param #(.DATA_W(32), .ADDR_W(3), .DEPTH(8), .OUT_REG(0), .WRITE_MODE(0), .INIT_CLEAR(1)) u0 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .be(be), .din(din), .addr(addr),
        .dout(dout_a[0]), .read_valid(valid_a[0]), .ready(ready_a[0]), .addr_err(err_a[0]));
    sp_ram_param #(.DATA_W(32), .ADDR_W(3), .DEPTH(8), .OUT_REG(1), .WRITE_MODE(0), .INIT_CLEAR(1)) u1 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .be(be), .din(din), .addr(addr),
        .dout(dout_a[1]), .read_valid(valid_a[1]), .ready(ready_a[1]), .addr_err(err_a[1]));
    sp_ram_param #(.DATA_W(32), .ADDR_W(3), .DEPTH(8), .OUT_REG(0), .WRITE_MODE(1), .INIT_CLEAR(1)) u2 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .be(be), .din(din), .addr(addr),
        .dout(dout_a[2]), .read_valid(valid_a[2]), .ready(ready_a[2]), .addr_err(err_a[2]));
    sp_ram_param #(.DATA_W(32), .ADDR_W(3), .DEPTH(6), .OUT_REG(0), .WRITE_MODE(0), .INIT_CLEAR(1)) u3 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .be(be), .din(din), .addr(addr),
        .dout(dout_a[3]), .read_valid(valid_a[3]), .ready(ready_a[3]), .addr_err(err_a[3]));
    sp_ram_param #(.DATA_W(32), .ADDR_W(3), .DEPTH(6), .OUT_REG(1), .WRITE_MODE(1), .INIT_CLEAR(1)) u4 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .be(be), .din(din), .addr(addr),
        .dout(dout_a[4]), .read_valid(valid_a[4]), .ready(ready_a[4]), .addr_err(err_a[4]));

    function automatic int cfg_dep(input int k);
        return (k >= 3) ? 6 : 8;
    endfunction
    function automatic bit cfg_oreg(input int k);
        return (k == 1) || (k == 4);
    endfunction
    function automatic bit cfg_wm(input int k);
        return (k == 2) || (k == 4);
    endfunction
    function automatic logic [31:0] lane_mask(input logic [3:0] b);
        return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got 0x%08h, expected 0x%08h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Behavioural model: word array, cycles-since-reset count, one-deep latency slot.
    logic [31:0] mm [NI][8];
    int          cnt_m     [NI];
    logic [31:0] exp_dout  [NI];
    logic        exp_valid [NI];
    logic        exp_err   [NI];
    logic        exp_ready [NI];
    logic        pv [NI];
    logic        pe [NI];
    logic [31:0] pd [NI];

    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < NI; k++) begin
            if (!rst) begin
                cnt_m[k] = 0;
                exp_dout[k] = 32'h0; exp_valid[k] = 1'b0; exp_err[k] = 1'b0; exp_ready[k] = 1'b0;
                pv[k] = 1'b0; pe[k] = 1'b0; pd[k] = 32'h0;
                for (int a = 0; a < 8; a++) mm[k][a] = 32'h0;
            end else begin
                bit          acc, oor, cv, ce;
                logic [31:0] cd;
                acc = ena && exp_ready[k];
                oor = (int'(addr) >= cfg_dep(k));
                cv = 1'b0; ce = 1'b0; cd = 32'h0;
                if (acc) begin
                    ce = oor;
                    if (wea) begin
                        if (!oor) mm[k][addr] = (mm[k][addr] & ~lane_mask(be)) | (din & lane_mask(be));
                        if (cfg_wm(k)) begin
                            cv = 1'b1;
                            cd = oor ? 32'h0 : mm[k][addr];
                        end
                    end else begin
                        cv = 1'b1;
                        cd = oor ? 32'h0 : mm[k][addr];
                    end
                end
                if (cfg_oreg(k)) begin
                    exp_valid[k] = pv[k]; exp_err[k] = pe[k];
                    if (pv[k]) exp_dout[k] = pd[k];
                    pv[k] = cv; pe[k] = ce; pd[k] = cd;
                end else begin
                    exp_valid[k] = cv; exp_err[k] = ce;
                    if (cv) exp_dout[k] = cd;
                end
                if (cnt_m[k] < 1000) cnt_m[k] = cnt_m[k] + 1;
                exp_ready[k] = (cnt_m[k] >= cfg_dep(k));
            end
        end
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            chk("dout", k, dout_a[k], exp_dout[k]);
            chk("read_valid", k, {31'h0, valid_a[k]}, {31'h0, exp_valid[k]});
            chk("addr_err", k, {31'h0, err_a[k]}, {31'h0, exp_err[k]});
            chk("ready", k, {31'h0, ready_a[k]}, {31'h0, exp_ready[k]});
        end
    end

    task automatic cyc(input logic e, input logic w, input logic [3:0] b, input logic [31:0] d, input logic [2:0] a);
        ena = e; wea = w; be = b; din = d; addr = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 0, {31'h0, ready_a[0]}, 32'h0);
        chk("rst_dout", 1, dout_a[1], 32'h0);
        ena = 1'b1; wea = 1'b0; addr = 3'd0;
        rst = 1'b1;

        // INIT with ena held high: ignored, ready after exactly 8 edges
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, 4'h0, 32'h0, 3'd0);
            if (i == 6) chk("init_ready_d6", 3, {31'h0, ready_a[3]}, 32'h1);
            if (i == 7) chk("init_ready_lo", 0, {31'h0, ready_a[0]}, 32'h0);
            if (i == 7) chk("init_novalid", 0, {31'h0, valid_a[0]}, 32'h0);
            if (i == 8) chk("init_ready_hi", 0, {31'h0, ready_a[0]}, 32'h1);
        end
        for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0, 4'h0, 32'h0, 3'(k));
        chk("init_zero", 0, dout_a[0], 32'h0);
        chk("init_zero_v", 0, {31'h0, valid_a[0]}, 32'h1);

        // Byte-lane write
        cyc(1'b1, 1'b1, 4'hF, 32'hAABBCCDD, 3'd2);
        cyc(1'b1, 1'b1, 4'h5, 32'h11223344, 3'd2);
        chk("wm1_merge", 2, dout_a[2], 32'hAA22CC44);
        chk("model_w2", 0, mm[0][2], 32'hAA22CC44);
        cyc(1'b1, 1'b0, 4'h0, 32'h0, 3'd2);
        chk("lane_read", 0, dout_a[0], 32'hAA22CC44);
        chk("lane_read_v", 0, {31'h0, valid_a[0]}, 32'h1);

        // Two-cycle latency, back-to-back reads
        for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, 4'hF, 32'h100 + k, 3'(k));
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b0, 4'h0, 32'h0, 3'(k));
            if (k == 0) chk("oreg_lat_v0", 1, {31'h0, valid_a[1]}, 32'h0);
            if (k == 1) chk("oreg_first", 1, dout_a[1], 32'h100);
            if (k == 1) chk("oreg_first_v", 1, {31'h0, valid_a[1]}, 32'h1);
        end
        cyc(1'b0, 1'b0, 4'h0, 32'h0, 3'd0);
        chk("oreg_last", 1, dout_a[1], 32'h107);
        cyc(1'b0, 1'b0, 4'h0, 32'h0, 3'd0);
        chk("oreg_idle_v", 1, {31'h0, valid_a[1]}, 32'h0);

        // Write-port read behaviour
        cyc(1'b1, 1'b1, 4'hF, 32'h12345678, 3'd5);
        cyc(1'b1, 1'b1, 4'hC, 32'hDEADBEEF, 3'd5);
        chk("wm1_data", 2, dout_a[2], 32'hDEAD5678);
        chk("wm1_valid", 2, {31'h0, valid_a[2]}, 32'h1);
        chk("wm0_hold", 0, dout_a[0], 32'h107);
        chk("wm0_novalid", 0, {31'h0, valid_a[0]}, 32'h0);

        // Out-of-range on DEPTH=6
        cyc(1'b1, 1'b1, 4'hF, 32'hFFFFFFFF, 3'd7);
        chk("oor_wr_err", 3, {31'h0, err_a[3]}, 32'h1);
        chk("oor_wr_nov", 3, {31'h0, valid_a[3]}, 32'h0);
        cyc(1'b1, 1'b0, 4'h0, 32'h0, 3'd7);
        chk("oor_rd_err", 3, {31'h0, err_a[3]}, 32'h1);
        chk("oor_rd_v", 3, {31'h0, valid_a[3]}, 32'h1);
        chk("oor_rd_d", 3, dout_a[3], 32'h0);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 1'b0, 4'h0, 32'h0, 3'(k));
            if (k == 0) chk("oor_keep0", 3, dout_a[3], 32'h100);
        end

        // Randomised traffic
        repeat (400) cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                         4'($urandom), $urandom, 3'($urandom));

        // Reset one cycle after a read request
        cyc(1'b1, 1'b1, 4'hF, 32'h5555AAAA, 3'd3);
        cyc(1'b1, 1'b0, 4'h0, 32'h0, 3'd3);
        rst = 1'b0;
        #1;
        chk("mid_rst_dout", 1, dout_a[1], 32'h0);
        chk("mid_rst_v", 1, {31'h0, valid_a[1]}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, 4'h0, 32'h0, 3'd3);
            if (i == 1) chk("rel_novalid", 1, {31'h0, valid_a[1]}, 32'h0);
            if (i == 7) chk("rel_ready_lo", 0, {31'h0, ready_a[0]}, 32'h0);
        end
        cyc(1'b1, 1'b0, 4'h0, 32'h0, 3'd3);
        chk("cleared_w3", 0, dout_a[0], 32'h0);
        chk("cleared_w3_v", 0, {31'h0, valid_a[0]}, 32'h1);
        repeat (3) cyc(1'b0, 1'b0, 4'h0, 32'h0, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sp_ram_param.md
Name: sp_ram_param

Overview:
- Parametrised single-port synchronous RAM. Next-generation storage element behind the FIFO datapath.
- Adds over the earlier fixed 32-bit RAM:
  - configurable width and depth
  - byte-lane write enables
  - selectable read latency
  - selectable write-port read behaviour
  - hardware clear-on-reset sequencer with a ready handshake
  - out-of-range address flagging
- The FIFO controller drives ena/wea/addr and samples dout when read_valid is high.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 3, address width in bits.
- DEPTH, 1<<ADDR_W, number of words; must be at most 2^ADDR_W.
- OUT_REG, 0, read latency select: 0 = 1-cycle read, 1 = 2-cycle read (extra output register).
- WRITE_MODE, 0, write-port read behaviour: 0 = no-change (dout holds), 1 = write-first (dout returns merged new word).
- INIT_CLEAR, 1, 1 = zero all words after reset before accepting accesses; 0 = skip clearing.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  access enable; ignored while ready=0.
- wea  in  1  1 = write, 0 = read; qualified by ena.
- be  in  DATA_W/8  byte write enables; bit i controls din[8i+7:8i].
- din  in  DATA_W  write data.
- addr  in  ADDR_W  word address.
- dout  out  DATA_W  read data.
- read_valid  out  1  one-cycle pulse: dout carries data for an accepted access.
- ready  out  1  1 = accesses accepted.
- addr_err  out  1  one-cycle pulse: an accepted access had addr >= DEPTH.

Behaviour:
- Reset (rst=0, asynchronous):
  - dout=0, read_valid=0, addr_err=0, ready=0; all pipeline registers cleared.
  - FSM goes to INIT if INIT_CLEAR=1, else READY.
  - Array contents are not reset asynchronously.
- FSM states: INIT, READY.
- INIT:
  - Internal counter runs 0..DEPTH-1, writing all-zeros to one word per cycle.
  - ena is ignored and produces no read_valid or addr_err.
  - After the write to DEPTH-1, the next state is READY.
  - ready rises on the first READY cycle, exactly DEPTH cycles after reset deassertion.
- READY: ready=1. An access is accepted when ena=1 and ready=1.
- Write (accepted, wea=1, addr<DEPTH):
  - Bytes with be[i]=1 are updated; others keep their value. be=0 updates nothing.
  - WRITE_MODE=0: dout holds its value, read_valid=0.
  - WRITE_MODE=1: dout = merged post-write word, read_valid=1, with the normal read latency.
- Read (accepted, wea=0, addr<DEPTH):
  - OUT_REG=0: dout updated and read_valid=1 on the edge that samples the request.
  - OUT_REG=1: both appear one edge later.
  - Back-to-back reads give back-to-back valids (full throughput, 1 access per cycle).
- Out-of-range access (addr>=DEPTH, only possible when DEPTH < 2^ADDR_W):
  - A write does not modify the array.
  - A read returns dout=0 with read_valid=1.
  - addr_err pulses with the same latency as read_valid.
  - A write in WRITE_MODE=0 pulses addr_err only.
- Idle (ena=0 or ready=0): read_valid=0, addr_err=0, dout holds its last value.
- Read-after-write to the same address on consecutive cycles returns the new data. There is no hazard: the write commits at the edge, before the next read samples.
- Reset mid-operation:
  - Reads in flight in the OUT_REG pipeline are discarded; no read_valid is produced after reset.
  - INIT restarts from address 0.
- Width rules:
  - Internal init counter is ADDR_W+1 bits, so DEPTH=2^ADDR_W terminates without wrap.
  - The address comparison is unsigned.

Test Plan:
- Reset plus INIT, defaults: release rst, hold ena=1/wea=0 during INIT. Required: ready=0 for exactly 8 cycles, no read_valid; then reads of addr 0..7 all return 0x00000000.
- Byte-lane write:
  - Write addr 2, din=0xAABBCCDD, be=4'b1111.
  - Then write din=0x11223344 with be=4'b0101.
  - Read addr 2. Required: dout=0xAA22CC44, read_valid one cycle after the read request (OUT_REG=0).
- Latency and throughput, OUT_REG=1:
  - Write addr k with data k+0x100 for k=0..7.
  - Issue 8 back-to-back reads of addr 0..7.
  - Required: 8 consecutive read_valid cycles starting 2 cycles after the first request, data 0x100..0x107 in order.
- WRITE_MODE=1:
  - Write addr 5, din=0xDEADBEEF, be=4'b1100 over prior 0x12345678.
  - Required: read_valid=1 with dout=0xDEAD5678 at read latency.
  - Same stimulus with WRITE_MODE=0: read_valid=0 and dout unchanged.
- Out-of-range, DEPTH=6, ADDR_W=3:
  - Write addr 7, then read addr 7.
  - Required: addr_err pulses for both accesses; the read returns dout=0 with read_valid=1; words 0..5 are unchanged.
- Reset mid-operation, OUT_REG=1:
  - Assert rst one cycle after a read request.
  - Required: dout=0 and read_valid=0 immediately; no valid pulse after release; ready low for DEPTH cycles; a prior write to addr 3 reads back as 0.
